// File: rtl/fft_spectrum_buffer.sv
// fft_spectrum_buffer: captures the first BINS magnitude samples of each FFT
// frame into a ping-pong bank pair and scales them to LCD bar heights. One
// bank is filled while the other is shown, so the LCD always reads a whole,
// stable frame.
//
// Optional feature macro: PEAK_HOLD_EN
//   defined   -> per-bin peak-hold registers with per-frame decay on rd_peak
//   undefined -> no peak storage, rd_peak is tied to 0
module fft_spectrum_buffer #(
  parameter int FFT_N = 128,
  parameter int BINS  = 64,
  parameter int AW    = 6,
  parameter int SHIFT = 4,
  parameter int MAX_H = 255,
  parameter int DECAY = 2
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic [15:0]   data_modulus,
  input  logic          data_sop,
  input  logic          data_eop,
  input  logic          data_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_height,
  output logic [7:0]    rd_peak,
  output logic          frame_ready,
  output logic          frame_done,
  output logic          frame_err
);

  localparam logic [AW:0] BINS_C  = (AW+1)'(BINS);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [7:0]  MAX_H_C = 8'(MAX_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        wr_bank_q, wr_bank_d;
  logic        frame_ready_q, frame_ready_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  rd_height_q, rd_height_d;

  // Two banks of bar heights; never reset, contents only matter once committed.
  logic [7:0]  bank_mem [0:1][0:BINS-1];

  logic        wr_en;
  logic [AW:0] acc_idx;
  logic [AW:0] acc_next;
  logic        commit;
  logic [15:0] shifted;
  logic [7:0]  h_scaled;
  logic        rd_in_range;

  // FFT_N only documents the frame length (eop marks the end in hardware);
  // DECAY is only consumed by the peak-hold build. Both fold into this sink.
  logic        param_unused;
  assign param_unused = (FFT_N < BINS) ^ (DECAY < 0);

  // Scale the incoming magnitude to a bar height, clamped to MAX_H.
  always_comb begin
    shifted  = data_modulus >> SHIFT;
    h_scaled = shifted[7:0];
    if (shifted > {8'd0, MAX_H_C}) begin
      h_scaled = MAX_H_C;
    end
  end

  // Capture FSM: chooses the bin to write, detects commit/drop, flips banks.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_bank_d     = wr_bank_q;
    frame_ready_d = frame_ready_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    wr_en         = 1'b0;
    acc_idx       = '0;
    commit        = 1'b0;

    if (data_valid) begin
      // A sop always restarts at bin 0, from any state; otherwise only
      // CAPTURE stores samples.
      if (data_sop) begin
        wr_en   = 1'b1;
        acc_idx = '0;
      end else if (state_q == S_CAPTURE) begin
        wr_en   = 1'b1;
        acc_idx = cnt_q;
      end
    end

    acc_next = acc_idx + CNT_ONE;

    if (wr_en) begin
      cnt_d = acc_next;
      if (acc_next == BINS_C) begin
        // All bins stored: commit now if this is also eop (BINS == FFT_N),
        // otherwise skip the rest of the frame.
        if (data_eop) begin
          commit = 1'b1;
        end else begin
          state_d = S_DISCARD;
        end
      end else if (data_eop) begin
        frame_err_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end else begin
        state_d = S_CAPTURE;
      end
    end else if (data_valid && data_eop && (state_q == S_DISCARD)) begin
      commit = 1'b1;
    end

    if (commit) begin
      wr_bank_d     = ~wr_bank_q;
      frame_done_d  = 1'b1;
      frame_ready_d = 1'b1;
      cnt_d         = '0;
      state_d       = S_IDLE;
    end
  end

  // Read port: display bank chosen by the bank select at the address edge.
  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < BINS_C);
    rd_height_d = 8'd0;
    if (frame_ready_q && rd_in_range) begin
      rd_height_d = bank_mem[~wr_bank_q][rd_addr];
    end
  end

  // Control and read-data registers with asynchronous reset.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      rd_height_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      rd_height_q   <= rd_height_d;
    end
  end

  // Bank write in the accept cycle, into the bank currently being filled.
  always_ff @(posedge clk_50m) begin
    if (wr_en) begin
      bank_mem[wr_bank_q][acc_idx[AW-1:0]] <= h_scaled;
    end
  end

  assign rd_height   = rd_height_q;
  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;

`ifdef PEAK_HOLD_EN
  localparam logic [7:0] DECAY_C = 8'(DECAY);

  logic [7:0] peak_q [0:BINS-1];
  logic [7:0] peak_d [0:BINS-1];
  logic [7:0] rd_peak_q, rd_peak_d;

  function automatic logic [7:0] sat_decay(input logic [7:0] p);
    if (p > DECAY_C) begin
      return p - DECAY_C;
    end
    return 8'd0;
  endfunction

  // In the frame_done cycle every peak takes max(new height, decayed peak).
  always_comb begin
    for (int i = 0; i < BINS; i++) begin
      peak_d[i] = peak_q[i];
      if (frame_done_q) begin
        if (bank_mem[~wr_bank_q][i] > sat_decay(peak_q[i])) begin
          peak_d[i] = bank_mem[~wr_bank_q][i];
        end else begin
          peak_d[i] = sat_decay(peak_q[i]);
        end
      end
    end
    rd_peak_d = 8'd0;
    if (rd_in_range) begin
      rd_peak_d = peak_q[rd_addr];
    end
  end

  // Peak-hold storage and peak read register with asynchronous reset.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BINS; i++) begin
        peak_q[i] <= 8'd0;
      end
      rd_peak_q <= 8'd0;
    end else begin
      peak_q    <= peak_d;
      rd_peak_q <= rd_peak_d;
    end
  end

  assign rd_peak = rd_peak_q;
`else
  assign rd_peak = 8'd0;
`endif

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Directed self-checking bench for fft_spectrum_buffer. Peak-hold expectations
// follow the PEAK_HOLD_EN macro.
module tb_fft_spectrum_buffer;

`ifdef PEAK_HOLD_EN
  localparam logic [15:0] EXP_PEAK_A = 16'd200;
  localparam logic [15:0] EXP_PEAK_B = 16'd198;
`else
  localparam logic [15:0] EXP_PEAK_A = 16'd0;
  localparam logic [15:0] EXP_PEAK_B = 16'd0;
`endif

  logic        clk_50m;
  logic        rst;
  logic [15:0] data_modulus;
  logic        data_sop;
  logic        data_eop;
  logic        data_valid;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_height;
  logic [7:0]  rd_peak;
  logic        frame_ready;
  logic        frame_done;
  logic        frame_err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int doneCount  = 0;
  int errCount   = 0;

  logic [15:0] frameData [0:255];
  logic [7:0]  dispModel [0:63];
  logic [7:0]  expSweep;

  fft_spectrum_buffer dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .data_modulus (data_modulus),
    .data_sop     (data_sop),
    .data_eop     (data_eop),
    .data_valid   (data_valid),
    .rd_addr      (rd_addr),
    .rd_height    (rd_height),
    .rd_peak      (rd_peak),
    .frame_ready  (frame_ready),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  // 50 MHz clock
  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // Pulse counters sampled away from the active edge
  always @(negedge clk_50m) begin
    if (frame_done === 1'b1) doneCount++;
    if (frame_err === 1'b1) errCount++;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] modulus, input logic sop,
                               input logic eop, input logic valid);
    @(negedge clk_50m);
    data_modulus = modulus;
    data_sop     = sop;
    data_eop     = eop;
    data_valid   = valid;
  endtask

  task automatic sendFrame(input int len, input int sopAt, input bit withEop);
    for (int i = 0; i < len; i++) begin
      applyStimulus(frameData[i], (i == 0) || (i == sopAt),
                    withEop && (i == len - 1), 1'b1);
    end
  endtask

  // Negedge after the last sample: check the pulses, then go idle
  task automatic finishFrame(input logic expDone, input logic expErr);
    @(negedge clk_50m);
    checkOutput("frame_done_pulse", frame_done, expDone);
    checkOutput("frame_err_pulse", frame_err, expErr);
    data_valid = 1'b0;
    data_sop   = 1'b0;
    data_eop   = 1'b0;
  endtask

  task automatic readBin(input logic [5:0] addr, input logic [7:0] expH);
    @(negedge clk_50m);
    rd_addr = addr;
    @(negedge clk_50m);
    checkOutput("rd_height", rd_height, expH);
  endtask

  initial begin
    rst          = 1'b1;
    data_modulus = 16'd0;
    data_sop     = 1'b0;
    data_eop     = 1'b0;
    data_valid   = 1'b0;
    rd_addr      = 6'd0;

    // Reset state
    repeat (3) @(negedge clk_50m);
    checkOutput("rst_frame_ready", frame_ready, 1'b0);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_rd_height", rd_height, 8'd0);
    checkOutput("rst_rd_peak", rd_peak, 8'd0);
    rst = 1'b0;
    readBin(6'd10, 8'd0);

    // Frame 1: modulus = 16*i, heights = i
    $display("[TB] frame 1: ramp");
    for (int i = 0; i < 128; i++) frameData[i] = 16'(16 * i);
    sendFrame(128, -1, 1'b1);
    finishFrame(1'b1, 1'b0);
    checkOutput("frame_ready_after_1", frame_ready, 1'b1);
    @(negedge clk_50m);
    checkOutput("frame_done_clears", frame_done, 1'b0);
    readBin(6'd10, 8'd10);
    readBin(6'd63, 8'd63);
    readBin(6'd0, 8'd0);
    checkOutput("done_count_1", 16'(doneCount), 16'd1);

    // Frame 2: heights 2*i, with clamp boundaries at bins 5..7
    $display("[TB] frame 2: clamp");
    for (int i = 0; i < 128; i++) frameData[i] = 16'(32 * i);
    frameData[5] = 16'hFFFF;
    frameData[6] = 16'h0FEF;
    frameData[7] = 16'h100F;
    sendFrame(128, -1, 1'b1);
    finishFrame(1'b1, 1'b0);
    readBin(6'd5, 8'd255);
    readBin(6'd6, 8'd254);
    readBin(6'd7, 8'd255);
    readBin(6'd10, 8'd20);
    readBin(6'd63, 8'd126);

    // Short frame: eop at sample 40 is dropped
    $display("[TB] short frame");
    for (int i = 0; i < 128; i++) frameData[i] = 16'd160;
    sendFrame(40, -1, 1'b1);
    finishFrame(1'b0, 1'b1);
    readBin(6'd5, 8'd255);
    readBin(6'd10, 8'd20);
    checkOutput("err_count_short", 16'(errCount), 16'd1);
    checkOutput("done_count_short", 16'(doneCount), 16'd2);

    // Valid samples without sop in IDLE are ignored, including an eop
    applyStimulus(16'd100, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'd100, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("stray_eop_no_err", frame_err, 1'b0);
    checkOutput("stray_eop_no_done", frame_done, 1'b0);

    // sop and eop on one sample: short frame
    applyStimulus(16'd800, 1'b1, 1'b1, 1'b1);
    finishFrame(1'b0, 1'b1);
    readBin(6'd10, 8'd20);
    checkOutput("err_count_sopeop", 16'(errCount), 16'd2);

    // Restart: 30 samples of 1600, then sop and a full frame of 48*i
    $display("[TB] restart frame");
    for (int i = 0; i < 30; i++) frameData[i] = 16'd1600;
    for (int i = 0; i < 128; i++) frameData[30 + i] = 16'(48 * i);
    sendFrame(158, 30, 1'b1);
    finishFrame(1'b1, 1'b0);
    readBin(6'd0, 8'd0);
    readBin(6'd5, 8'd15);
    readBin(6'd29, 8'd87);
    readBin(6'd40, 8'd120);
    checkOutput("done_count_restart", 16'(doneCount), 16'd3);
    checkOutput("err_count_restart", 16'(errCount), 16'd2);

    // Back-to-back frames with data_valid always high and a sweeping reader
    $display("[TB] continuous frames with sweep");
    for (int b = 0; b < 64; b++) dispModel[b] = 8'(3 * b);
    expSweep = 8'd0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk_50m);
      if (c > 0) checkOutput("sweep", rd_height, expSweep);
      data_valid   = 1'b1;
      data_modulus = (c < 128) ? 16'((255 - c) * 16) : 16'((c - 128 + 100) * 16);
      data_sop     = (c == 0) || (c == 128);
      data_eop     = (c == 127) || (c == 255);
      rd_addr      = c[5:0];
      expSweep     = dispModel[c[5:0]];
      if (c == 127) for (int b = 0; b < 64; b++) dispModel[b] = 8'(255 - b);
      if (c == 255) for (int b = 0; b < 64; b++) dispModel[b] = 8'(b + 100);
    end
    @(negedge clk_50m);
    checkOutput("sweep", rd_height, expSweep);
    checkOutput("sweep_done_pulse", frame_done, 1'b1);
    data_valid = 1'b0;
    data_sop   = 1'b0;
    data_eop   = 1'b0;
    readBin(6'd63, 8'd163);
    checkOutput("done_count_sweep", 16'(doneCount), 16'd5);

    // Peak hold: reset, frame A (bin 3 = 200), frame B (bin 3 = 0)
    $display("[TB] peak hold");
    @(negedge clk_50m);
    rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) frameData[i] = 16'd0;
    frameData[3] = 16'd3200;
    sendFrame(128, -1, 1'b1);
    finishFrame(1'b1, 1'b0);
    readBin(6'd3, 8'd200);
    checkOutput("peak_a_bin3", rd_peak, EXP_PEAK_A);
    frameData[3] = 16'd0;
    sendFrame(128, -1, 1'b1);
    finishFrame(1'b1, 1'b0);
    readBin(6'd3, 8'd0);
    checkOutput("peak_b_bin3", rd_peak, EXP_PEAK_B);
    readBin(6'd4, 8'd0);
    checkOutput("peak_b_bin4", rd_peak, 16'd0);

    // Reset in the middle of a frame
    frameData[3] = 16'd3200;
    sendFrame(20, -1, 1'b0);
    @(negedge clk_50m);
    rst        = 1'b1;
    data_valid = 1'b0;
    data_sop   = 1'b0;
    @(negedge clk_50m);
    checkOutput("midrst_frame_ready", frame_ready, 1'b0);
    checkOutput("midrst_rd_peak", rd_peak, 16'd0);
    rst = 1'b0;
    readBin(6'd3, 8'd0);
    checkOutput("midrst_peak_bin3", rd_peak, 16'd0);
    checkOutput("midrst_ready_after", frame_ready, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
